// File: rtl/axis_ad9361_dual.sv
// AXI-stream to dual-channel AD9361 DAC sample unpacker: a word carries two I/Q sample pairs.
// Latency: one cycle from data_rd to registered sample outputs; a written word is readable the next cycle.
// Backpressure: s_axis_tready drops while the word FIFO is full; requests on an empty FIFO underflow.

// Generic single-clock FIFO with head-of-queue data always visible.
// Latency: a write is visible at rd_dat on the following cycle.
// Backpressure: wr_rdy deasserts when full or in reset; a pop on an empty FIFO is ignored.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     data_clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    output logic                     wr_rdy,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_pop,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_rdy  = ~rst & (count < FULL);
    assign wr_fire = wr_vld & wr_rdy;
    assign rd_fire = rd_pop & (count != '0);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge data_clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge data_clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module axis_ad9361_dual #(
    parameter int SAMPS_WIDTH  = 128,
    parameter int REVERSE_DATA = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int SATURATE     = 1
) (
    input  logic                   data_clk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [SAMPS_WIDTH-1:0] s_axis_tdata,
    input  logic                   data_rd,
    output logic [11:0]            data_i0,
    output logic [11:0]            data_q0,
    output logic [11:0]            data_i1,
    output logic [11:0]            data_q1,
    output logic                   data_valid,
    output logic                   frame_end,
    output logic                   underflow,
    output logic [15:0]            underflow_count
);
    typedef struct packed {
        logic                   last;
        logic [SAMPS_WIDTH-1:0] dat;
    } word_t;

    typedef enum logic {PH_A, PH_B} ph_t;

    word_t                         wr_word;
    word_t                         head;
    logic [$clog2(FIFO_DEPTH):0]   count;
    logic                          pop;
    logic [15:0]                   slot [8];
    ph_t                           ph;

    assign wr_word = '{last: s_axis_tlast, dat: s_axis_tdata};
    // The FSM only reaches PH_B with a word at the head, so the pop always hits data.
    assign pop     = data_rd & (ph == PH_B);

    fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .data_clk (data_clk),
        .rst      (rst),
        .wr_vld   (s_axis_tvalid),
        .wr_rdy   (s_axis_tready),
        .wr_dat   (wr_word),
        .rd_pop   (pop),
        .rd_dat   (head),
        .count    (count)
    );

    for (genvar k = 0; k < 8; k++) begin : g_slot
        assign slot[k] = (REVERSE_DATA != 0) ? head.dat[16*(7-k) +: 16] : head.dat[16*k +: 16];
    end

    function automatic logic [11:0] conv(input logic [15:0] s);
        logic [11:0] r;
        r = s[11:0];
        if (SATURATE != 0) begin
            if ($signed(s) > 16'sd2047) begin
                r = 12'h7FF;
            end else if ($signed(s) < -16'sd2048) begin
                r = 12'h800;
            end
        end
        return r;
    endfunction

    always_ff @(posedge data_clk) begin
        if (rst) begin
            ph              <= PH_A;
            data_i0         <= '0;
            data_q0         <= '0;
            data_i1         <= '0;
            data_q1         <= '0;
            data_valid      <= 1'b0;
            frame_end       <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= '0;
        end else begin
            data_valid <= data_rd;
            frame_end  <= 1'b0;
            underflow  <= 1'b0;
            if (data_rd) begin
                case (ph)
                    PH_A: begin
                        if (count != '0) begin
                            data_i0 <= conv(slot[7]);
                            data_q0 <= conv(slot[6]);
                            data_i1 <= conv(slot[5]);
                            data_q1 <= conv(slot[4]);
                            ph      <= PH_B;
                        end else begin
                            data_i0   <= '0;
                            data_q0   <= '0;
                            data_i1   <= '0;
                            data_q1   <= '0;
                            underflow <= 1'b1;
                            if (underflow_count != 16'hFFFF) begin
                                underflow_count <= underflow_count + 16'd1;
                            end
                        end
                    end
                    PH_B: begin
                        data_i0   <= conv(slot[3]);
                        data_q0   <= conv(slot[2]);
                        data_i1   <= conv(slot[1]);
                        data_q1   <= conv(slot[0]);
                        frame_end <= head.last;
                        ph        <= PH_A;
                    end
                    default: ph <= PH_A;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_ad9361_dual.sv
// Scoreboard bench for axis_ad9361_dual: a saturating and a truncating instance share stimulus,
// expected outputs are queued at request time and popped by per-instance monitors.
module tb_axis_ad9361_dual;
    logic         data_clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic [127:0] s_axis_tdata = '0;
    logic         data_rd = 1'b0;

    logic         s_axis_tready, t_tready;
    logic [11:0]  s_i0, s_q0, s_i1, s_q1, t_i0, t_q0, t_i1, t_q1;
    logic         s_vld, s_fe, s_uf, t_vld, t_fe, t_uf;
    logic [15:0]  s_ucnt, t_ucnt;

    always #5 data_clk = ~data_clk;

    axis_ad9361_dual #(.SAMPS_WIDTH(128), .REVERSE_DATA(0), .FIFO_DEPTH(4), .SATURATE(1)) dut (
        .data_clk(data_clk), .rst(rst), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .data_rd(data_rd),
        .data_i0(s_i0), .data_q0(s_q0), .data_i1(s_i1), .data_q1(s_q1), .data_valid(s_vld),
        .frame_end(s_fe), .underflow(s_uf), .underflow_count(s_ucnt));

    axis_ad9361_dual #(.SAMPS_WIDTH(128), .REVERSE_DATA(0), .FIFO_DEPTH(4), .SATURATE(0)) dut_t (
        .data_clk(data_clk), .rst(rst), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(t_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .data_rd(data_rd),
        .data_i0(t_i0), .data_q0(t_q0), .data_i1(t_i1), .data_q1(t_q1), .data_valid(t_vld),
        .frame_end(t_fe), .underflow(t_uf), .underflow_count(t_ucnt));

    typedef struct {
        int          cyc;
        logic [11:0] i0, q0, i1, q1;
        logic        uf, fe;
    } exp_t;

    exp_t q_s[$];
    exp_t q_t[$];
    exp_t es_m, et_m;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   produced = 0;
    int   accepted = 0;

    always @(posedge data_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] i0, q0, i1, q1, input logic uf, fe);
        exp_t e;
        e.cyc = 0; e.i0 = i0; e.q0 = q0; e.i1 = i1; e.q1 = q1; e.uf = uf; e.fe = fe;
        return e;
    endfunction

    function automatic logic [127:0] seqw(input logic [15:0] b);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[16*(7-k) +: 16] = b + 16'(k + 1);
        return w;
    endfunction

    // Packed form {cycle, i0, q0, i1, q1, underflow, frame_end} for a single comparison.
    always @(negedge data_clk) begin
        if (s_vld) begin
            if (q_s.size() == 0) begin
                chk("sat_unexpected_output", {32'(cyc), s_i0, s_q0, s_i1, s_q1, s_uf, s_fe}, '0);
            end else begin
                es_m = q_s.pop_front();
                chk("sat_sample", {32'(cyc), s_i0, s_q0, s_i1, s_q1, s_uf, s_fe},
                    {32'(es_m.cyc), es_m.i0, es_m.q0, es_m.i1, es_m.q1, es_m.uf, es_m.fe});
            end
        end
    end

    always @(negedge data_clk) begin
        if (t_vld) begin
            if (q_t.size() == 0) begin
                chk("trunc_unexpected_output", {32'(cyc), t_i0, t_q0, t_i1, t_q1, t_uf, t_fe}, '0);
            end else begin
                et_m = q_t.pop_front();
                chk("trunc_sample", {32'(cyc), t_i0, t_q0, t_i1, t_q1, t_uf, t_fe},
                    {32'(et_m.cyc), et_m.i0, et_m.q0, et_m.i1, et_m.q1, et_m.uf, et_m.fe});
            end
        end
    end

    // Called just after a rising edge; the request is sampled on the next edge, output seen one edge later.
    task automatic req(input exp_t es, input exp_t et);
        es.cyc = cyc + 1;
        et.cyc = cyc + 1;
        q_s.push_back(es);
        q_t.push_back(et);
        data_rd = 1'b1;
        @(posedge data_clk);
        #1;
    endtask

    task automatic req1(input exp_t e);
        req(e, e);
    endtask

    task automatic req_word(input logic [11:0] b, input logic fe);
        req1(mk(b + 12'd1, b + 12'd2, b + 12'd3, b + 12'd4, 1'b0, 1'b0));
        req1(mk(b + 12'd5, b + 12'd6, b + 12'd7, b + 12'd8, 1'b0, fe));
    endtask

    task automatic send(input logic [127:0] w, input logic last);
        int b;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = w;
        s_axis_tlast  = last;
        for (b = 0; b < 200; b++) begin
            @(negedge data_clk);
            if (s_axis_tready) break;
        end
        if (b >= 200) chk("send_timeout", 96'(b), 96'd0);
        @(posedge data_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic step();
        @(posedge data_clk);
        #1;
    endtask

    task automatic do_reset();
        data_rd = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        step(); step();
        @(negedge data_clk);
        chk("reset_tready", 96'(s_axis_tready), 96'd0);
        chk("reset_outputs", {s_i0, s_q0, s_i1, s_q1, s_vld, s_uf, s_fe}, '0);
        chk("reset_ucount", 96'(s_ucnt), 96'd0);
        step();
        rst = 1'b0;
        @(negedge data_clk);
        chk("post_reset_tready", 96'(s_axis_tready), 96'd1);
        step();

        // Basic unpack, read issued the cycle right after the write.
        send(seqw(16'd0), 1'b0);
        req_word(12'd0, 1'b0);
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("count_after_pop", 96'(dut.u_fifo.count), 96'd0);
        step();

        // Saturation boundaries versus truncation.
        send({16'h7FFF, 16'h8000, 16'h07FF, 16'hF800, 16'hFFFF, 16'h0800, 16'hF7FF, 16'h0005}, 1'b0);
        req(mk(12'h7FF, 12'h800, 12'h7FF, 12'h800, 1'b0, 1'b0),
            mk(12'hFFF, 12'h000, 12'h7FF, 12'h800, 1'b0, 1'b0));
        req(mk(12'hFFF, 12'h7FF, 12'h800, 12'h005, 1'b0, 1'b0),
            mk(12'hFFF, 12'h800, 12'h7FF, 12'h005, 1'b0, 1'b0));
        data_rd = 1'b0;

        // Fill with no reads: exactly four words accepted.
        accepted = 0;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_axis_tdata = seqw(16'(32 * k));
            @(negedge data_clk);
            if (!s_axis_tready) break;
            @(posedge data_clk);
            #1;
            accepted++;
        end
        s_axis_tvalid = 1'b0;
        chk("fill_accepted", 96'(accepted), 96'd4);
        chk("full_tready", 96'(s_axis_tready), 96'd0);
        step();
        req_word(12'd0, 1'b0);
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("tready_after_pop", 96'(s_axis_tready), 96'd1);
        chk("count_after_one_pop", 96'(dut.u_fifo.count), 96'd3);
        step();
        for (int k = 1; k < 4; k++) req_word(12'(32 * k), 1'b0);
        data_rd = 1'b0;

        // Frame end only on the sixth output.
        send(seqw(16'd300), 1'b0);
        send(seqw(16'd400), 1'b0);
        send(seqw(16'd500), 1'b1);
        req_word(12'd300, 1'b0);
        req_word(12'd400, 1'b0);
        req_word(12'd500, 1'b1);
        data_rd = 1'b0;

        // Random gaps on both sides; order must be preserved.
        produced = 0;
        fork
            begin
                for (int w = 0; w < 4; w++) begin
                    repeat ($urandom_range(0, 3)) step();
                    send(seqw(16'(600 + 20 * w)), w == 3);
                    produced++;
                end
            end
            begin
                for (int r = 0; r < 8; r++) begin
                    int b;
                    data_rd = 1'b0;
                    repeat ($urandom_range(0, 3)) step();
                    b = 0;
                    while (produced <= r / 2 && b < 200) begin
                        step();
                        b++;
                    end
                    if (b >= 200) chk("consumer_timeout", 96'(b), 96'd0);
                    if (r % 2 == 0)
                        req1(mk(12'(601 + 10 * r), 12'(602 + 10 * r), 12'(603 + 10 * r), 12'(604 + 10 * r), 1'b0, 1'b0));
                    else
                        req1(mk(12'(595 + 10 * r), 12'(596 + 10 * r), 12'(597 + 10 * r), 12'(598 + 10 * r), 1'b0, r == 7));
                end
                data_rd = 1'b0;
            end
        join

        // Reset while half a word is consumed.
        send(seqw(16'd700), 1'b1);
        req1(mk(12'd701, 12'd702, 12'd703, 12'd704, 1'b0, 1'b0));
        data_rd = 1'b0;
        rst = 1'b1;
        @(negedge data_clk);
        chk("tready_in_reset", 96'(s_axis_tready), 96'd0);
        step();
        rst = 1'b0;
        @(negedge data_clk);
        chk("count_after_reset", 96'(dut.u_fifo.count), 96'd0);
        step();
        req1(mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0));
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("ucount_after_reset_uf", 96'(s_ucnt), 96'd1);
        step();

        // Underflow counting and saturation.
        do_reset();
        for (int k = 0; k < 3; k++) req1(mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0));
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("ucount_3", 96'(s_ucnt), 96'd3);
        step();
        for (int k = 0; k < 65531; k++) req1(mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0));
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("ucount_fffe", 96'(s_ucnt), 96'hFFFE);
        step();
        req1(mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0));
        req1(mk(12'd0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b0));
        data_rd = 1'b0;
        @(negedge data_clk);
        chk("ucount_sat", 96'(s_ucnt), 96'hFFFF);
        chk("ucount_sat_trunc_inst", 96'(t_ucnt), 96'hFFFF);

        repeat (3) step();
        @(negedge data_clk);
        chk("sat_queue_drained", 96'(q_s.size()), 96'd0);
        chk("trunc_queue_drained", 96'(q_t.size()), 96'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
